// File: rtl/kwc_pkg.sv
// Shared types and constants for the 5x5 kernel window sequencer.
package kwc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } kwc_state_e;

  localparam int KERNEL = 5;
  localparam int HALF   = 2;

  // Bits needed to hold coordinates 0..n-1; never less than one bit.
  function automatic int coord_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/kwc_pos_counter.sv
// Raster column/row position counter; the row saturates on the last pixel of a frame.
module kwc_pos_counter #(
  parameter int W  = 8,
  parameter int H  = 8,
  parameter int CW = 3,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          advance,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          col_last,
  output logic          last_pix
);

  localparam logic [CW-1:0] COL_MAX = CW'(W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(H - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  assign col_last = (col_q == COL_MAX);
  assign last_pix = col_last && (row_q == ROW_MAX);
  assign col      = col_q;
  assign row      = row_q;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear) begin
      col_d = '0;
      row_d = '0;
    end else if (advance) begin
      if (col_last) begin
        col_d = '0;
        if (!last_pix) row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/kernel_window_ctrl.sv
// Frame sequencer for the 5x5 line-buffer window generator.
// Optional macro KWC_STALL_CNT_EN adds the stall_cnt output (held-window cycle counter).
module kernel_window_ctrl
  import kwc_pkg::*;
#(
  parameter int IMG_Width  = 8,
  parameter int IMG_Height = 8,
  parameter int CW         = coord_w(IMG_Width),
  parameter int RW         = coord_w(IMG_Height)
) (
  input  logic          CLK,
  input  logic          CLR,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          lb_we,
  output logic          win_valid,
  input  logic          win_ready,
  output logic [RW-1:0] win_row,
  output logic [CW-1:0] win_col,
  output logic          busy,
  output logic          frame_done,
`ifdef KWC_STALL_CNT_EN
  output logic [15:0]   stall_cnt,
`endif
  output logic [2:0]    state_dbg
);

  // Handshakes: a pixel moves when in_valid && in_ready; a window is consumed
  // when win_valid && win_ready. Neither valid may depend on its ready.
  kwc_state_e state_q, state_d;

  logic          win_valid_q, win_valid_d;
  logic [RW-1:0] win_row_q, win_row_d;
  logic [CW-1:0] win_col_q, win_col_d;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          col_last, last_pix;
  logic          accept, win_set, frame_start;

  assign frame_start = (state_q == ST_IDLE) && start;
  assign in_ready    = ((state_q == ST_FILL) || (state_q == ST_RUN)) &&
                       (!win_valid_q || win_ready);
  assign accept      = in_valid && in_ready;
  assign lb_we       = accept;
  // Windows whose left edge would wrap into the previous row are never flagged.
  assign win_set     = accept && (row >= RW'(KERNEL - 1)) && (col >= CW'(KERNEL - 1));

  kwc_pos_counter #(
    .W (IMG_Width),
    .H (IMG_Height),
    .CW(CW),
    .RW(RW)
  ) u_pos (
    .clk     (CLK),
    .rst_n   (CLR),
    .clear   (frame_start),
    .advance (accept),
    .col     (col),
    .row     (row),
    .col_last(col_last),
    .last_pix(last_pix)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_FILL;
      ST_FILL:  if (accept && col_last && (row == RW'(KERNEL - 2))) state_d = ST_RUN;
      ST_RUN:   if (accept && last_pix) state_d = ST_DRAIN;
      ST_DRAIN: if (!win_valid_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    win_valid_d = win_valid_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    if (win_set) begin
      win_valid_d = 1'b1;
      win_row_d   = row - RW'(HALF);
      win_col_d   = col - CW'(HALF);
    end else if (win_valid_q && win_ready) begin
      win_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q     <= ST_IDLE;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
    end else begin
      state_q     <= state_d;
      win_valid_q <= win_valid_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
    end
  end

`ifdef KWC_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (frame_start) stall_d = '0;
    else if (win_valid_q && !win_ready && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) stall_q <= '0;
    else      stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

  assign win_valid  = win_valid_q;
  assign win_row    = win_row_q;
  assign win_col    = win_col_q;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = (state_q == ST_DONE);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_kernel_window_ctrl.sv
// Randomized bench for kernel_window_ctrl against a pixel-index frame model.
module tb_kernel_window_ctrl;
  import kwc_pkg::*;

  localparam int W = 8;
  localparam int H = 8;
  localparam int CW = 3;
  localparam int RW = 3;
  localparam int NWIN = (W - 4) * (H - 4);

  logic          CLK = 1'b0;
  logic          CLR, start, in_valid, win_ready;
  logic          in_ready, lb_we, win_valid, busy, frame_done;
  logic [RW-1:0] win_row;
  logic [CW-1:0] win_col;
  logic [2:0]    state_dbg;
`ifdef KWC_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  kernel_window_ctrl #(.IMG_Width(W), .IMG_Height(H)) dut (
    .CLK       (CLK),
    .CLR       (CLR),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .lb_we     (lb_we),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_row   (win_row),
    .win_col   (win_col),
    .busy      (busy),
    .frame_done(frame_done),
`ifdef KWC_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- frame model ----------------
  // phase: 0 idle, 1 accepting pixels, 2 draining, 3 done pulse
  int          m_phase, m_idx, m_wr, m_wc, m_stall;
  logic        m_wv;
  logic [15:0] exp_q[$];

  always @(posedge CLK or negedge CLR) begin : model
    logic acc, set;
    int   r, c, nphase;
    if (!CLR) begin
      m_phase = 0; m_idx = 0; m_wv = 1'b0; m_wr = 0; m_wc = 0; m_stall = 0;
      exp_q.delete();
    end else begin
      acc    = in_valid && (m_phase == 1) && (!m_wv || win_ready);
      set    = 1'b0;
      r      = m_idx / W;
      c      = m_idx % W;
      nphase = m_phase;
      if (m_phase == 0 && start) m_stall = 0;
      else if (m_wv && !win_ready && m_stall < 65535) m_stall++;
      case (m_phase)
        0: if (start) begin
             nphase = 1;
             m_idx  = 0;
             exp_q.delete();
             for (int rr = 4; rr < H; rr++)
               for (int cc = 4; cc < W; cc++)
                 exp_q.push_back(16'((rr - 2) * 16 + (cc - 2)));
           end
        1: if (acc) begin
             set = (r >= 4) && (c >= 4);
             m_idx++;
             if (m_idx == W * H) nphase = 2;
           end
        2: if (!m_wv) nphase = 3;
        default: nphase = 0;
      endcase
      if (set) begin
        m_wv = 1'b1; m_wr = r - 2; m_wc = c - 2;
      end else if (m_wv && win_ready) begin
        m_wv = 1'b0;
      end
      m_phase = nphase;
    end
  end

  // ---------------- compare / scoreboard ----------------
  int hs_cnt, fd_cnt, acc_cnt, first_win_cyc, acc44_cyc;
  int got[0:63];

  always @(negedge CLK) begin : cmp
    logic        e_rdy;
    logic [15:0] e;
    cyc++;
    if (!CLR) begin
      check("rst_in_ready", in_ready, 0);
      check("rst_lb_we", lb_we, 0);
      check("rst_busy", busy, 0);
      check("rst_win_valid", win_valid, 0);
      check("rst_frame_done", frame_done, 0);
`ifdef KWC_STALL_CNT_EN
      check("rst_stall_cnt", stall_cnt, 0);
`endif
    end else begin
      e_rdy = (m_phase == 1) && (!m_wv || win_ready);
      check("in_ready", in_ready, e_rdy);
      check("lb_we", lb_we, in_valid && e_rdy);
      check("busy", busy, m_phase != 0);
      check("frame_done", frame_done, m_phase == 3);
      check("win_valid", win_valid, m_wv);
      if (m_wv) begin
        check("win_row", win_row, m_wr);
        check("win_col", win_col, m_wc);
      end
`ifdef KWC_STALL_CNT_EN
      check("stall_cnt", stall_cnt, m_stall);
`endif
      if (lb_we) begin
        acc_cnt++;
        if (acc_cnt == 4 * W + 5) acc44_cyc = cyc;
      end
      if (win_valid && first_win_cyc < 0) first_win_cyc = cyc;
      if (win_valid && win_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL win_extra: got window %0d,%0d expected none", win_row, win_col);
        end else begin
          e = exp_q.pop_front();
          check("win_order", win_row * 16 + win_col, e);
        end
        if (hs_cnt < 64) got[hs_cnt] = win_row * 16 + win_col;
        hs_cnt++;
      end
      if (frame_done) fd_cnt++;
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic begin_frame();
    hs_cnt = 0; fd_cnt = 0; acc_cnt = 0; first_win_cyc = -1; acc44_cyc = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // mode: 0 full rate, 1 hold window (2,3) for 5 cycles, 2 gappy random, 3 start during RUN
  task automatic run_frame(input int mode);
    int hold;
    bit done;
    hold = 0;
    done = 1'b0;
    for (int k = 0; k < 3000 && !done; k++) begin
      in_valid  = (mode == 2) ? ($urandom_range(0, 1) == 1) : 1'b1;
      win_ready = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      start     = (mode == 3) && (acc_cnt == 45);
      if (mode == 1 && win_valid && win_row == 3'd2 && win_col == 3'd3 && hold < 5) begin
        win_ready = 1'b0;
        hold++;
        #1;
        check("bp_in_ready", in_ready, 0);
        check("bp_lb_we", lb_we, 0);
        check("bp_coord", win_row * 16 + win_col, 2 * 16 + 3);
      end
      tick();
      if (fd_cnt > 0) done = 1'b1;
    end
    start = 1'b0;
    check("frame_timeout", done, 1);
    check("win_count", hs_cnt, NWIN);
    check("frame_done_pulses", fd_cnt, 1);
    check("first_window", got[0], 2 * 16 + 2);
    check("last_window", got[NWIN - 1], 5 * 16 + 5);
    check("first_win_latency", first_win_cyc - acc44_cyc, 1);
    check("busy_after_done", busy, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    CLR = 1'b0; start = 1'b0; in_valid = 1'b1; win_ready = 1'b1;
    hs_cnt = 0; fd_cnt = 0; acc_cnt = 0; first_win_cyc = -1; acc44_cyc = -1;
    repeat (3) tick();
    check("rst_state", state_dbg, ST_IDLE);
    CLR = 1'b1;
    repeat (5) tick();
    check("idle_in_ready", in_ready, 0);
    check("idle_lb_we", lb_we, 0);
    check("idle_busy", busy, 0);

    begin_frame();
    run_frame(0);

    begin_frame();
    run_frame(1);
`ifdef KWC_STALL_CNT_EN
    check("stall_after_bp", stall_cnt, 5);
`endif

    begin_frame();
`ifdef KWC_STALL_CNT_EN
    check("stall_cleared_by_start", stall_cnt, 0);
`endif
    run_frame(2);

    // abort part-way through a frame
    begin_frame();
    in_valid = 1'b1; win_ready = 1'b1;
    for (int k = 0; k < 200 && acc_cnt < 30; k++) tick();
    check("abort_reached", acc_cnt >= 30, 1);
    CLR = 1'b0;
    #1;
    check("abort_win_valid", win_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 0);
    tick();
    CLR = 1'b1;
    tick();

    begin_frame();
    run_frame(0);

    begin_frame();
    run_frame(3);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
